// File: rtl/button_switch_reader_pkg.sv
// Shared constants for the switch/button reader: register map and counter width.
package button_switch_reader_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 2;
  localparam int PCNT_W = 8;

  localparam logic [ADDR_W-1:0] ADDR_SW    = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_BTN   = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_FLAGS = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_PCNT  = 2'd3;
endpackage

// File: rtl/button_switch_reader_if.sv
// Processor-side read port of the switch/button reader.
interface button_switch_reader_if;
  import button_switch_reader_pkg::*;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              irq_pending;

  modport master (output rd_en, rd_addr, input  rd_data, irq_pending);
  modport slave  (input  rd_en, rd_addr, output rd_data, irq_pending);
endinterface

// File: rtl/button_switch_reader_debounce.sv
// One input bit: 2-flop synchronizer plus hold-time debounce.
// rise pulses combinationally in the cycle whose edge raises stable.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic stable,
  output logic rise
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) stable_d = sync2_q;
      else                  cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= din;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign rise   = stable_d & ~stable_q;
endmodule

// File: rtl/button_switch_reader.sv
// Debounced switch/button reader: sticky press flags, btn0 press counter,
// and a 4-word read-only window with registered read data.
module button_switch_reader
  import button_switch_reader_pkg::*;
#(
  parameter int NUM_SW          = 16,
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SW-1:0]  sw_in,
  input  logic [NUM_BTN-1:0] btn_in,
  button_switch_reader_if.slave bus
);
  localparam int NUM_IN = NUM_SW + NUM_BTN;

  logic [NUM_IN-1:0]  raw, stable, rise;
  logic [NUM_SW-1:0]  sw_stable;
  logic [NUM_BTN-1:0] btn_stable, press;
  logic               unused_sw_rise;

  assign raw = {btn_in, sw_in};

  for (genvar i = 0; i < NUM_IN; i++) begin : g_db
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .rst    (rst),
      .din    (raw[i]),
      .stable (stable[i]),
      .rise   (rise[i])
    );
  end

  assign sw_stable      = stable[NUM_SW-1:0];
  assign btn_stable     = stable[NUM_IN-1:NUM_SW];
  assign press          = rise[NUM_IN-1:NUM_SW];
  assign unused_sw_rise = ^rise[NUM_SW-1:0];

  logic [NUM_BTN-1:0] flags_q, flags_d, clr;
  logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d, rd_word;

  always_comb begin
    rd_word = '0;
    case (bus.rd_addr)
      ADDR_SW:    rd_word[NUM_SW-1:0]  = sw_stable;
      ADDR_BTN:   rd_word[NUM_BTN-1:0] = btn_stable;
      ADDR_FLAGS: rd_word[NUM_BTN-1:0] = flags_q;
      ADDR_PCNT:  rd_word[PCNT_W-1:0]  = pcnt_q;
      default:    rd_word = '0;
    endcase
  end

  // Only flags actually returned are cleared; a same-edge press survives.
  always_comb begin
    clr       = (bus.rd_en && bus.rd_addr == ADDR_FLAGS) ? flags_q : '0;
    flags_d   = (flags_q & ~clr) | press;
    pcnt_d    = pcnt_q + PCNT_W'(press[0]);
    rd_data_d = bus.rd_en ? rd_word : rd_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q   <= '0;
      pcnt_q    <= '0;
      rd_data_q <= '0;
    end else begin
      flags_q   <= flags_d;
      pcnt_q    <= pcnt_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.irq_pending = |flags_q;
endmodule
